// File: rtl/mp_pkg.sv
// Shared multi-precision constants and the conditional-subtract FSM encoding.
package mp_pkg;

  localparam int unsigned MP_WIDTH   = 1027;
  localparam int unsigned MP_CHUNK_W = 257;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SUB,
    ST_FIN
  } mp_state_e;

endpackage

// File: rtl/mp_sub_chunk.sv
// One slice of the borrow chain: {b_out,d} = a - b - b_in.
module mp_sub_chunk #(
  parameter int unsigned CHUNK_W = 257
) (
  input  logic [CHUNK_W-1:0] a,
  input  logic [CHUNK_W-1:0] b,
  input  logic               b_in,
  output logic [CHUNK_W-1:0] d,
  output logic               b_out
);

  logic [CHUNK_W:0] diff;

  always_comb begin
    diff  = {1'b0, a} - {1'b0, b} - {{CHUNK_W{1'b0}}, b_in};
    d     = diff[CHUNK_W-1:0];
    b_out = diff[CHUNK_W];
  end

endmodule

// File: rtl/mp_cond_sub.sv
// Final conditional subtraction S mod M (S < 2M), computed slice-serially over NUM_CHUNKS cycles.
module mp_cond_sub
  import mp_pkg::*;
#(
  parameter int unsigned WIDTH   = MP_WIDTH,
  parameter int unsigned CHUNK_W = MP_CHUNK_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH:0]   in_sum,
  input  logic [WIDTH-1:0] in_mod,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic             sub_taken,
  output logic             range_err,
  output logic             done
);

  localparam int unsigned NUM_CHUNKS = (WIDTH + 1) / CHUNK_W;
  localparam int unsigned CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

  mp_state_e          state, state_nxt;
  logic [WIDTH:0]     reg_s, reg_m, reg_d, d_next;
  logic [CNT_W-1:0]   cnt;
  logic               borrow;
  logic [CHUNK_W-1:0] slice_d;
  logic               slice_b;
  logic               last;
  logic               accept;

  assign last   = (cnt == CNT_W'(NUM_CHUNKS - 1));
  assign accept = start && (state == ST_IDLE || state == ST_FIN);
  assign busy   = (state != ST_IDLE);

  mp_sub_chunk #(.CHUNK_W(CHUNK_W)) u_chunk (
    .a     (reg_s[cnt*CHUNK_W +: CHUNK_W]),
    .b     (reg_m[cnt*CHUNK_W +: CHUNK_W]),
    .b_in  (borrow),
    .d     (slice_d),
    .b_out (slice_b)
  );

  // Difference with the current slice merged in, so the final slice can feed the result directly.
  always_comb begin
    d_next                          = reg_d;
    d_next[cnt*CHUNK_W +: CHUNK_W]  = slice_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_SUB;
      ST_SUB:  if (last)  state_nxt = ST_FIN;
      ST_FIN:  state_nxt = start ? ST_SUB : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_s     <= '0;
      reg_m     <= '0;
      reg_d     <= '0;
      cnt       <= '0;
      borrow    <= 1'b0;
      result    <= '0;
      sub_taken <= 1'b0;
      range_err <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        reg_s  <= in_sum;
        reg_m  <= {1'b0, in_mod};
        cnt    <= '0;
        borrow <= 1'b0;
      end else if (state == ST_SUB) begin
        reg_d  <= d_next;
        borrow <= slice_b;
        cnt    <= cnt + CNT_W'(1);
        if (last) begin
          done <= 1'b1;
          if (!slice_b) begin
            result    <= d_next[WIDTH-1:0];
            sub_taken <= 1'b1;
            range_err <= d_next[WIDTH];
          end else begin
            result    <= reg_s[WIDTH-1:0];
            sub_taken <= 1'b0;
            range_err <= 1'b0;
          end
        end
      end
    end
  end

endmodule
